// File: rtl/chip8_timers.sv
// Chip-8 delay and sound timers: 60 Hz prescaler, DT/ST down-counters with CPU
// write access, and the SILENT/SOUNDING FSM that drives the sound controller.
module chip8_timers #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned TICK_HZ     = 60,
  parameter int unsigned MIN_AUDIBLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       dt_we,
  input  logic [7:0] dt_wdata,
  input  logic       st_we,
  input  logic [7:0] st_wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       tick,
  output logic       is_on
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [7:0]       MIN_LOAD = 8'(MIN_AUDIBLE);

  localparam logic [0:0] SILENT   = 1'b0;
  localparam logic [0:0] SOUNDING = 1'b1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             wrap;
  logic [7:0]       dt_next;
  logic [7:0]       st_next;
  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             is_on_next;

  // Prescaler: wraps every DIV unpaused cycles, frozen while paused
  always_comb begin
    wrap     = 1'b0;
    cnt_next = cnt;
    if (!pause) begin
      if (cnt == CNT_MAX) begin
        wrap     = 1'b1;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // Timers: write beats decrement; decrement saturates at zero
  always_comb begin
    dt_next = dt_value;
    st_next = st_value;
    if (dt_we) begin
      dt_next = dt_wdata;
    end else if (wrap && (dt_value != 8'd0)) begin
      dt_next = dt_value - 8'd1;
    end
    if (st_we) begin
      st_next = st_wdata;
    end else if (wrap && (st_value != 8'd0)) begin
      st_next = st_value - 8'd1;
    end
  end

  // Sound FSM: loads below MIN_AUDIBLE neither start nor stop the tone
  always_comb begin
    state_next = state;
    if (st_next == 8'd0) begin
      state_next = SILENT;
    end else if (st_we && (st_wdata >= MIN_LOAD)) begin
      state_next = SOUNDING;
    end
    is_on_next = (state_next == SOUNDING) && !pause;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      dt_value <= 8'd0;
      st_value <= 8'd0;
      state    <= SILENT;
      tick     <= 1'b0;
      is_on    <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      dt_value <= dt_next;
      st_value <= st_next;
      state    <= state_next;
      tick     <= wrap;
      is_on    <= is_on_next;
    end
  end

endmodule

// File: tb/tb_chip8_timers.sv
// Randomized and directed bench for chip8_timers against an integer-level
// reference model of the prescaler phase, timer values and tone state.
module tb_chip8_timers;

  localparam int DIV      = 10;
  localparam int MIN_AUD  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause;
  logic       dt_we;
  logic [7:0] dt_wdata;
  logic       st_we;
  logic [7:0] st_wdata;
  logic [7:0] dt_value;
  logic [7:0] st_value;
  logic       tick;
  logic       is_on;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase;
  int m_dt;
  int m_st;
  bit m_snd;
  bit m_tick;
  bit m_on;

  chip8_timers #(
    .CLK_HZ     (600),
    .TICK_HZ    (60),
    .MIN_AUDIBLE(MIN_AUD)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .pause   (pause),
    .dt_we   (dt_we),
    .dt_wdata(dt_wdata),
    .st_we   (st_we),
    .st_wdata(st_wdata),
    .dt_value(dt_value),
    .st_value(st_value),
    .tick    (tick),
    .is_on   (is_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_dt    = 0;
    m_st    = 0;
    m_snd   = 1'b0;
    m_tick  = 1'b0;
    m_on    = 1'b0;
  endtask

  // One clock edge worth of behaviour, using the inputs present at the edge
  task automatic model_update();
    bit wrap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    wrap = !pause && (m_phase == DIV - 1);
    if (!pause) m_phase = (m_phase + 1) % DIV;
    m_tick = wrap;
    if (dt_we) m_dt = int'(dt_wdata);
    else if (wrap && m_dt > 0) m_dt = m_dt - 1;
    if (st_we) begin
      m_st = int'(st_wdata);
      if (m_st == 0) m_snd = 1'b0;
      else if (m_st >= MIN_AUD) m_snd = 1'b1;
    end else if (wrap && m_st > 0) begin
      m_st = m_st - 1;
      if (m_st == 0) m_snd = 1'b0;
    end
    m_on = m_snd && !pause;
  endtask

  task automatic check_outputs();
    check("tick", int'(tick), int'(m_tick));
    check("dt_value", int'(dt_value), m_dt);
    check("st_value", int'(st_value), m_st);
    check("is_on", int'(is_on), int'(m_on));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
  endtask

  task automatic write_st(input int v);
    st_we    = 1'b1;
    st_wdata = 8'(v);
    step();
    st_we    = 1'b0;
  endtask

  // Advance until the next edge is a prescaler wrap (bounded)
  task automatic wait_wrap_next();
    for (int i = 0; i < DIV + 1; i++) begin
      if (m_phase == DIV - 1) return;
      step();
    end
  endtask

  initial begin
    int ticks_seen;
    rst_n    = 1'b0;
    pause    = 1'b0;
    dt_we    = 1'b0;
    dt_wdata = 8'd0;
    st_we    = 1'b0;
    st_wdata = 8'd0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Free run: ticks at cycles 10, 20, 30 after release
    ticks_seen = 0;
    for (int i = 0; i < 35; i++) begin
      step();
      if (tick) ticks_seen++;
    end
    check("tick_count_35", ticks_seen, 3);

    // Audible load counts down to zero with no underflow
    write_st(3);
    repeat (40) step();

    // Sub-audible load stays silent; then a minimal audible load
    write_st(1);
    repeat (15) step();
    write_st(2);
    repeat (25) step();

    // Writes coincident with a tick win over the decrement
    wait_wrap_next();
    dt_we    = 1'b1;
    dt_wdata = 8'h05;
    st_we    = 1'b1;
    st_wdata = 8'h10;
    step();
    check("dt_load_on_tick", int'(dt_value), 5);
    dt_we = 1'b0;
    st_we = 1'b0;
    repeat (12) step();

    // Pause freezes everything and mutes the tone without losing state
    write_st(5);
    repeat (3) step();
    pause = 1'b1;
    repeat (50) step();
    check("st_hold_pause", int'(st_value), 5);
    pause = 1'b0;
    step();
    check("is_on_after_pause", int'(is_on), 1);
    repeat (15) step();

    // Asynchronous reset mid-count clears without a clock edge
    write_st(200);
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("async_st_clear", int'(st_value), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (25) step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      pause    = ($urandom_range(99, 0) < 8);
      dt_we    = ($urandom_range(99, 0) < 5);
      dt_wdata = ($urandom_range(1, 0) == 0) ? 8'($urandom_range(4, 0)) : 8'($urandom);
      st_we    = ($urandom_range(99, 0) < 5);
      st_wdata = ($urandom_range(3, 0) != 0) ? 8'($urandom_range(4, 0)) : 8'($urandom);
      step();
    end
    pause = 1'b0;
    dt_we = 1'b0;
    st_we = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
